// File: rtl/avion_pkg.sv
// Shared definitions for the avion CPU memory side: opcodes, MMIO addresses,
// loader FSM states and the bus word type.
package avion_pkg;

   localparam int AVION_DATA_W = 10;
   localparam int AVION_ADDR_W = 6;

   typedef logic [AVION_DATA_W-1:0] word_t;

   localparam logic [3:0] LOD = 4'd0;
   localparam logic [3:0] STO = 4'd1;
   localparam logic [3:0] ADD = 4'd2;
   localparam logic [3:0] SUB = 4'd3;
   localparam logic [3:0] MUL = 4'd4;
   localparam logic [3:0] JMP = 4'd6;
   localparam logic [3:0] JMZ = 4'd7;
   localparam logic [3:0] HLT = 4'd9;

   localparam logic [AVION_ADDR_W-1:0] ADDR_STATUS   = 6'd60;
   localparam logic [AVION_ADDR_W-1:0] ADDR_CYCLES   = 6'd61;
   localparam logic [AVION_ADDR_W-1:0] ADDR_SWITCHES = 6'd62;
   localparam logic [AVION_ADDR_W-1:0] ADDR_LEDS     = 6'd63;

   typedef enum logic {
      LD_IDLE = 1'b0,
      LD_LOAD = 1'b1
   } ld_state_e;

endpackage

// File: rtl/avion_mmio_regs.sv
// MMIO register bank: sticky halt flag, LED register, free-running cycle
// counter and a two-flop synchronizer for the board switches.
module avion_mmio_regs
   import avion_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_status,
   input  logic                     wr_leds,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0]    switches,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic [DATA_WIDTH-1:0]    leds,
   output logic                     halted
);

   logic                  halted_q, halted_d;
   logic [DATA_WIDTH-1:0] leds_q, leds_d;
   logic [DATA_WIDTH-1:0] cycles_q, cycles_d;
   logic [DATA_WIDTH-1:0] sw_meta_q, sw_meta_d;
   logic [DATA_WIDTH-1:0] sw_sync_q, sw_sync_d;

   always_comb begin
      halted_d  = halted_q | wr_status;
      leds_d    = wr_leds ? wr_data : leds_q;
      cycles_d  = cycles_q + DATA_WIDTH'(1);
      sw_meta_d = switches;
      sw_sync_d = sw_meta_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halted_q  <= 1'b0;
         leds_q    <= '0;
         cycles_q  <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         halted_q  <= halted_d;
         leds_q    <= leds_d;
         cycles_q  <= cycles_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
      end
   end

   // Reads return the pre-edge register value; the parent registers rd_data.
   always_comb begin
      rd_data = '0;
      case (rd_addr)
         ADDRESS_WIDTH'(ADDR_STATUS):   rd_data = {{(DATA_WIDTH-1){1'b0}}, halted_q};
         ADDRESS_WIDTH'(ADDR_CYCLES):   rd_data = cycles_q;
         ADDRESS_WIDTH'(ADDR_SWITCHES): rd_data = sw_sync_q;
         ADDRESS_WIDTH'(ADDR_LEDS):     rd_data = leds_q;
         default:                       rd_data = '0;
      endcase
   end

   assign leds   = leds_q;
   assign halted = halted_q;

endmodule

// File: rtl/avion_mem_responder.sv
// Memory-side responder for avion_cpu: synchronous RAM, loader port, and an
// MMIO window at the top of the address space when AVION_MMIO_EN is defined.
module avion_mem_responder
   import avion_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10,
   parameter int DEPTH         = 64,
   parameter int MMIO_BASE     = 60
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_we,
   input  logic [ADDRESS_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0]    i_ram_data_in,
   output logic [DATA_WIDTH-1:0]    o_ram_data_out,
   input  logic                     ld_mode,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [ADDRESS_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0]    ld_data,
   input  logic [DATA_WIDTH-1:0]    switches,
   output logic [DATA_WIDTH-1:0]    leds,
   output logic                     halted
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   ld_state_e             state_q, state_d;
   logic                  ld_ready_q, ld_ready_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [IDX_W-1:0]      cpu_idx, ld_idx, mem_widx;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  ld_fire, cpu_wr, rd_force_zero;
   logic                  cpu_is_mmio;
   logic [DATA_WIDTH-1:0] mmio_rdata;

   assign cpu_idx = i_addr[IDX_W-1:0];
   assign ld_idx  = ld_addr[IDX_W-1:0];

   // NOTE: sequential state uses <= so every flop samples pre-edge values;
   // always_comb blocks use = since they describe plain combinational nets.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= LD_IDLE;
         ld_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_ready_q <= ld_ready_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LD_IDLE: if (ld_mode)  state_d = LD_LOAD;
         LD_LOAD: if (!ld_mode) state_d = LD_IDLE;
         default:               state_d = LD_IDLE;
      endcase
   end

   // The CPU is locked out both when the loader is requesting and for the
   // one cycle the FSM takes to leave LOAD.
   always_comb begin
      ld_ready_d    = (state_d == LD_LOAD);
      ld_fire       = ld_valid && ld_ready_q;
      cpu_wr        = i_we && !ld_mode && (state_q == LD_IDLE);
      rd_force_zero = (state_d == LD_LOAD);
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = cpu_idx;
      mem_wdata = i_ram_data_in;
      if (ld_fire) begin
         mem_we    = 1'b1;
         mem_widx  = ld_idx;
         mem_wdata = ld_data;
      end else if (cpu_wr && !cpu_is_mmio) begin
         mem_we    = 1'b1;
      end
   end

   // NOTE: the RAM array has no reset so it can map onto a block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_widx] <= mem_wdata;
   end

   always_comb begin
      if (rd_force_zero)    rdata_d = '0;
      else if (cpu_is_mmio) rdata_d = mmio_rdata;
      else                  rdata_d = mem_q[cpu_idx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdata_q <= '0;
      else      rdata_q <= rdata_d;
   end

   assign o_ram_data_out = rdata_q;
   assign ld_ready       = ld_ready_q;

`ifdef AVION_MMIO_EN
   logic wr_status, wr_leds;

   assign cpu_is_mmio = (32'(cpu_idx) >= MMIO_BASE);
   assign wr_status   = cpu_wr && cpu_is_mmio && (cpu_idx == IDX_W'(ADDR_STATUS));
   assign wr_leds     = cpu_wr && cpu_is_mmio && (cpu_idx == IDX_W'(ADDR_LEDS));

   avion_mmio_regs #(
      .ADDRESS_WIDTH (IDX_W),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_mmio_regs (
      .clk       (clk),
      .rst       (rst),
      .wr_status (wr_status),
      .wr_leds   (wr_leds),
      .wr_data   (i_ram_data_in),
      .rd_addr   (cpu_idx),
      .switches  (switches),
      .rd_data   (mmio_rdata),
      .leds      (leds),
      .halted    (halted)
   );
`else
   logic unused_switches;

   assign cpu_is_mmio     = 1'b0;
   assign mmio_rdata      = '0;
   assign leds            = '0;
   assign halted          = 1'b0;
   assign unused_switches = ^switches;
`endif

endmodule

// File: tb/tb_avion_mem_responder.sv
// Self-checking bench for avion_mem_responder: directed vector table, MMIO or
// plain-RAM sequences depending on AVION_MMIO_EN, then randomized traffic.
`timescale 1ns/1ps
module tb_avion_mem_responder;
   import avion_pkg::*;

   localparam int AW        = 6;
   localparam int DW        = 10;
   localparam int DEPTH     = 64;
   localparam int MMIO_BASE = 60;
`ifdef AVION_MMIO_EN
   localparam bit MMIO = 1'b1;
`else
   localparam bit MMIO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_we = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_ram_data_in = '0;
   logic [DW-1:0] o_ram_data_out;
   logic          ld_mode = 1'b0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic [DW-1:0] switches = '0;
   logic [DW-1:0] leds;
   logic          halted;

   always #5 clk = ~clk;

   avion_mem_responder dut (
      .clk            (clk),
      .rst            (rst),
      .i_we           (i_we),
      .i_addr         (i_addr),
      .i_ram_data_in  (i_ram_data_in),
      .o_ram_data_out (o_ram_data_out),
      .ld_mode        (ld_mode),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .switches       (switches),
      .leds           (leds),
      .halted         (halted)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
      end
   endtask

   // Reference model: memory image plus the architectural registers.
   word_t       m_mem [DEPTH];
   bit          m_known [DEPTH];
   word_t       m_out;
   bit          m_out_known;
   bit          m_ready;
   word_t       m_leds;
   bit          m_halted;
   int unsigned m_edges;
   word_t       m_sw_hist1, m_sw_hist2;
   bit          m_load_active;

   task automatic model_reset();
      m_out         = '0;
      m_out_known   = 1'b1;
      m_ready       = 1'b0;
      m_leds        = '0;
      m_halted      = 1'b0;
      m_edges       = 0;
      m_sw_hist1    = '0;
      m_sw_hist2    = '0;
      m_load_active = 1'b0;
   endtask

   // Advance the model by one rising edge using the inputs currently driven.
   task automatic model_edge();
      int a;
      int la;
      bit mmio_hit;
      a        = int'(i_addr) % DEPTH;
      la       = int'(ld_addr) % DEPTH;
      mmio_hit = MMIO && (a >= MMIO_BASE);
      if (!rst) begin
         model_reset();
         return;
      end
      m_out_known = 1'b1;
      if (ld_mode)                   m_out = '0;
      else if (mmio_hit && a == 60)  m_out = DW'(m_halted);
      else if (mmio_hit && a == 61)  m_out = DW'(m_edges % 1024);
      else if (mmio_hit && a == 62)  m_out = m_sw_hist2;
      else if (mmio_hit)             m_out = m_leds;
      else begin
         m_out       = m_mem[a];
         m_out_known = m_known[a];
      end
      if (m_load_active && ld_valid) begin
         m_mem[la]   = ld_data;
         m_known[la] = 1'b1;
      end else if (i_we && !ld_mode && !m_load_active) begin
         if (!mmio_hit) begin
            m_mem[a]   = i_ram_data_in;
            m_known[a] = 1'b1;
         end else if (a == 60) m_halted = 1'b1;
         else if (a == 63)     m_leds   = i_ram_data_in;
      end
      m_edges++;
      m_sw_hist2    = m_sw_hist1;
      m_sw_hist1    = switches;
      m_ready       = ld_mode;
      m_load_active = ld_mode;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      if (m_out_known) check({tag, " rdata"}, o_ram_data_out, m_out);
      check({tag, " ld_ready"}, DW'(ld_ready), DW'(m_ready));
      check({tag, " leds"}, leds, m_leds);
      check({tag, " halted"}, DW'(halted), DW'(m_halted));
   endtask

   typedef struct {
      bit            mode;
      bit            valid;
      logic [AW-1:0] laddr;
      logic [DW-1:0] ldata;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_out;
      bit            exp_ready;
   } vec_t;

   vec_t vecs [$];

   initial begin
      word_t v1, v2;
      bit    seen;

      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      model_reset();

      // Reset state
      tick();
      tick();
      check("reset rdata", o_ram_data_out, 10'h000);
      check("reset ld_ready", DW'(ld_ready), 10'h000);
      check("reset leds", leds, 10'h000);
      check("reset halted", DW'(halted), 10'h000);
      rst = 1'b1;

      // mode valid laddr ldata we addr wdata exp_out exp_ready
      vecs.push_back('{1, 1,  0, 10'h032, 0,  0, 10'h000, 10'h000, 1}); // entering LOAD, no transfer yet
      vecs.push_back('{1, 1,  0, 10'h032, 0,  0, 10'h000, 10'h000, 1});
      vecs.push_back('{1, 1, 50, 10'h005, 0,  0, 10'h000, 10'h000, 1});
      vecs.push_back('{1, 1, 52, 10'h0AB, 0,  0, 10'h000, 10'h000, 1});
      vecs.push_back('{0, 0,  0, 10'h000, 0, 50, 10'h000, 10'h005, 0});
      vecs.push_back('{0, 0,  0, 10'h000, 1, 52, 10'h032, 10'h0AB, 0}); // read during write: old value
      vecs.push_back('{0, 0,  0, 10'h000, 0, 52, 10'h000, 10'h032, 0});
      vecs.push_back('{0, 0,  0, 10'h000, 0,  0, 10'h000, 10'h032, 0});
      vecs.push_back('{1, 1,  5, 10'h111, 1,  5, 10'h222, 10'h000, 1}); // loader vs CPU contention
      vecs.push_back('{1, 1,  5, 10'h111, 1,  5, 10'h222, 10'h000, 1});
      vecs.push_back('{0, 0,  0, 10'h000, 1,  5, 10'h222, 10'h111, 0}); // CPU write while leaving LOAD
      vecs.push_back('{0, 0,  0, 10'h000, 0,  5, 10'h000, 10'h111, 0});

      foreach (vecs[i]) begin
         ld_mode       = vecs[i].mode;
         ld_valid      = vecs[i].valid;
         ld_addr       = vecs[i].laddr;
         ld_data       = vecs[i].ldata;
         i_we          = vecs[i].we;
         i_addr        = vecs[i].addr;
         i_ram_data_in = vecs[i].wdata;
         tick();
         check($sformatf("vec%0d rdata", i), o_ram_data_out, vecs[i].exp_out);
         check($sformatf("vec%0d ld_ready", i), DW'(ld_ready), DW'(vecs[i].exp_ready));
      end
      i_we = 1'b0;

      // Fill every word through the loader so the random phase has a known image
      ld_mode  = 1'b1;
      ld_valid = 1'b0;
      tick();
      ld_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         ld_addr = AW'(i);
         ld_data = DW'((i * 37 + 11) % 1024);
         tick();
         check_model("fill");
      end
      ld_mode  = 1'b0;
      ld_valid = 1'b0;
      tick();
      check_model("fill exit");

`ifdef AVION_MMIO_EN
      // LED register: write, then read back
      i_we = 1'b1; i_addr = 6'd63; i_ram_data_in = 10'h2A5;
      tick();
      check("leds after write", leds, 10'h2A5);
      check("leds read during write", o_ram_data_out, 10'h000);
      i_we = 1'b0;
      tick();
      check("leds readback", o_ram_data_out, 10'h2A5);

      // Switch synchronizer: visible within three edges
      i_addr   = 6'd62;
      switches = 10'h155;
      seen     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (o_ram_data_out == 10'h155) seen = 1'b1;
      end
      check("switches within 3", DW'(seen), 10'h001);
      check("switches value", o_ram_data_out, 10'h155);

      // Cycle counter: ten edges apart
      i_addr = 6'd61;
      tick();
      v1 = o_ram_data_out;
      check_model("cycles first");
      repeat (10) tick();
      v2 = o_ram_data_out;
      check("cycles delta", v2 - v1, 10'd10);

      // Sticky halt across idle cycles and a loader episode
      i_we = 1'b1; i_addr = 6'd60; i_ram_data_in = DW'($urandom);
      tick();
      check("halted set", DW'(halted), 10'h001);
      i_we = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         check($sformatf("halted hold%0d", k), DW'(halted), 10'h001);
      end
      ld_mode = 1'b1;
      tick();
      tick();
      ld_mode = 1'b0;
      tick();
      tick();
      check("halted after load", DW'(halted), 10'h001);
      check("status read", o_ram_data_out, 10'h001);
      i_addr = 6'd63;
      tick();
`else
      // Without the MMIO window address 63 is ordinary RAM
      i_we = 1'b1; i_addr = 6'd63; i_ram_data_in = 10'h3FF;
      tick();
      i_addr = 6'd60; i_ram_data_in = 10'h155;
      tick();
      i_we = 1'b0; i_addr = 6'd63;
      tick();
      check("ram63 readback", o_ram_data_out, 10'h3FF);
      check("leds tied", leds, 10'h000);
      check("halted tied", DW'(halted), 10'h000);
      i_addr = 6'd60;
      tick();
      check("ram60 readback", o_ram_data_out, 10'h155);
`endif

      // Asynchronous reset clears outputs mid-cycle, no clock edge needed
      check_model("pre reset");
      #3;
      rst = 1'b0;
      #1;
      check("async rdata", o_ram_data_out, 10'h000);
      check("async halted", DW'(halted), 10'h000);
      check("async leds", leds, 10'h000);
      check("async ld_ready", DW'(ld_ready), 10'h000);
      model_reset();

`ifdef AVION_MMIO_EN
      // A LED write coinciding with reset is lost
      i_we = 1'b1; i_addr = 6'd63; i_ram_data_in = 10'h3C3;
      tick();
      check("leds write in reset", leds, 10'h000);
      i_we = 1'b0;
`else
      tick();
`endif
      rst = 1'b1;
      tick();
      check_model("post reset");

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 19) == 0) ld_mode = ~ld_mode;
         ld_valid      = ($urandom_range(0, 1) == 1);
         ld_addr       = AW'($urandom);
         ld_data       = DW'($urandom);
         i_we          = ($urandom_range(0, 2) == 0);
         i_addr        = AW'($urandom);
         i_ram_data_in = DW'($urandom);
         if ($urandom_range(0, 31) == 0) switches = DW'($urandom);
         tick();
         check_model($sformatf("rnd%0d", n));
      end
      ld_mode = 1'b0;
      i_we    = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/avion_mem_responder.md
Name: avion_mem_responder

Overview:
- Memory-side responder for the avion_cpu bus (MAR/RAMWr/MDRIn out of the CPU, MDROut back into it).
- Replaces the bare testbench RAM with three parts: a 64x10 synchronous RAM, a small memory-mapped I/O window, and a loader port.
- The loader port lets an external agent fill program memory while the CPU is held.
- Sits between avion_cpu and the board-level top (switches/LEDs).

Parameters:
- ADDRESS_WIDTH, 6, bus address width.
- DATA_WIDTH, 10, bus data width.
- DEPTH, 64, number of RAM words.
- MMIO_BASE, 60, first address of the MMIO window (60..63).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_we  in  1  CPU write enable (RAMWr).
- i_addr  in  ADDRESS_WIDTH  CPU address (MAR).
- i_ram_data_in  in  DATA_WIDTH  CPU write data (MDRIn).
- o_ram_data_out  out  DATA_WIDTH  read data to CPU (MDROut), registered.
- ld_mode  in  1  loader owns memory; CPU access blocked.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted this cycle.
- ld_addr  in  ADDRESS_WIDTH  loader address.
- ld_data  in  DATA_WIDTH  loader data.
- switches  in  DATA_WIDTH  asynchronous board switches.
- leds  out  DATA_WIDTH  LED register.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_ram_data_out=0, leds=0, halted=0, cycle counter=0, switch synchronizer=0, ld_ready=0.
  - RAM contents are not reset.
- Read latency is 1 cycle. The address sampled at edge N produces data on o_ram_data_out after edge N, valid through edge N+1.
- Read-during-write to the same address returns the old value. This applies to RAM and to MMIO registers.
- CPU write (i_we=1, ld_mode=0) commits at the edge.
- Address map with MMIO enabled:
  - 0..59: RAM.
  - 60 STATUS: read {9'b0, halted}. Any write sets halted=1 (sticky until reset).
  - 61 CYCLES: read-only 10-bit free-running counter, increments every cycle, wraps 1023->0. Writes ignored.
  - 62 SWITCHES: read-only, returns the 2-flop-synchronized value of switches. Writes ignored.
  - 63 LEDS: read/write register, drives leds directly.
- The RAM cells behind 60..63 are reachable only through the loader.
- Loader FSM, two states:
  - IDLE -> LOAD when ld_mode=1.
  - LOAD -> IDLE when ld_mode=0.
  - In LOAD, ld_ready=1. A transfer fires when ld_valid && ld_ready and writes ld_data to RAM[ld_addr]; loader writes always go to RAM, including 60..63.
  - In LOAD, CPU writes are dropped and o_ram_data_out is forced to 0.
  - ld_ready is registered: it rises the cycle after entering LOAD and falls the cycle after ld_mode drops.
- Simultaneous events:
  - When ld_mode and i_we are both high, the loader wins and the CPU write is discarded.
  - A CPU write to 63 in the same cycle as a reset is lost (reset dominates).
- Address wrap: i_addr is used modulo DEPTH, with no out-of-range behaviour.
- Counter continues counting during LOAD and while halted.

Optional Feature:
- Macro: AVION_MMIO_EN.
- Defined: MMIO window exactly as described above.
- Undefined:
  - All addresses 0..63 are plain RAM.
  - leds ties to 0 and halted ties to 0.
  - The counter and switch synchronizer are not built.

Decomposition:
- Shared package avion_pkg holds:
  - Opcode constants (LOD=0, STO=1, ADD=2, SUB=3, MUL=4, JMP=6, JMZ=7, HLT=9).
  - MMIO address constants (ADDR_STATUS=60, ADDR_CYCLES=61, ADDR_SWITCHES=62, ADDR_LEDS=63).
  - Loader state enum.
  - A word typedef of DATA_WIDTH bits.
- One natural sub-module: avion_mmio_regs. It contains halted, leds, the cycle counter and the switch synchronizer, and takes decoded write strobes and a read-select address. The RAM array stays in the parent.

Test Plan:
- Loader fill: ld_mode=1, write 0x032 to addr 0, 0x005 to addr 50 (one per cycle, ld_ready=1) -> after ld_mode=0, CPU read of addr 50 returns 0x005 one cycle later.
- CPU store/load: i_we=1, addr 52, data 0x032 -> next-cycle read of 52 returns 0x032. A same-cycle read of 52 during the write returns the prior value.
- MMIO:
  - Write 0x2A5 to 63 -> leds=0x2A5 next edge, and reading 63 returns 0x2A5.
  - switches=0x155 -> read of 62 returns 0x155 no later than 3 cycles after the change.
  - Two reads of 61 taken 10 cycles apart differ by 10 modulo 1024.
- Halt: CPU write of any value to 60 -> halted=1, held across 20 cycles and across ld_mode toggling. Pulling rst low clears it immediately, without waiting for a clock.
- Contention: ld_mode=1, ld_valid=1 to addr 5 (0x111) while i_we=1 to addr 5 (0x222) -> RAM[5]=0x111, and o_ram_data_out=0 throughout LOAD.
- Build without AVION_MMIO_EN: write 0x3FF to 63 -> reads back 0x3FF from RAM, and leds stays 0.
